// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and source encoding for the register-file writeback arbiter.
//   WORDSIZE : register-file word width
//   REG_NUM  : number of architectural registers
//   AW       : register index width, log2(REG_NUM)
//   src_e    : producer encoding used by the round-robin pointer
package rf_wb_arbiter_pkg;

  localparam int WORDSIZE = 32;
  localparam int REG_NUM  = 32;
  localparam int AW       = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // The source that gets priority after 's' has been served.
  function automatic src_e other_src(src_e s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Producer-to-arbiter writeback handshake.
//   valid : result offered by the producer
//   ready : arbiter slot can take the result this cycle
//   rd    : destination register index
//   data  : result value
// master = producer side, slave = arbiter side.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int WORDSIZE_P = WORDSIZE,
  parameter int AW_P       = AW
);

  logic                  valid;
  logic                  ready;
  logic [AW_P-1:0]       rd;
  logic [WORDSIZE_P-1:0] data;

  modport master (output valid, rd, data, input ready);
  modport slave  (input valid, rd, data, output ready);

endinterface

// File: rtl/rf_wb_arbiter_wb_slot.sv
// One-entry writeback holding slot.
//   CLK, reset : clock and synchronous active-high reset
//   valid      : producer offer
//   ready      : slot can accept this cycle (empty, or being drained now)
//   in_rd/in_data : offered destination and value
//   grant      : arbiter is writing this slot's entry this cycle
//   pend/rd/data  : held entry
// Offers targeting x0 complete the handshake but are never stored.
module wb_slot #(
  parameter int WORDSIZE = 32,
  parameter int AW       = 5
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                valid,
  output logic                ready,
  input  logic [AW-1:0]       in_rd,
  input  logic [WORDSIZE-1:0] in_data,
  input  logic                grant,
  output logic                pend,
  output logic [AW-1:0]       rd,
  output logic [WORDSIZE-1:0] data
);

  logic                pend_q, pend_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [WORDSIZE-1:0] data_q, data_d;

  // Draining and refilling in the same cycle keeps one result per cycle.
  assign ready = !reset && (!pend_q || grant);

  always_comb begin
    pend_d = pend_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (grant) begin
      pend_d = 1'b0;
    end
    if (valid && ready && (in_rd != '0)) begin
      pend_d = 1'b1;
      rd_d   = in_rd;
      data_d = in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pend_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign pend = pend_q;
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
//   CLK, reset   : clock and synchronous active-high reset
//   alu, mem     : producer handshakes (slave side)
//   regwrite/write1/write_data : register-file write port, driven from the
//                  granted slot, all zero when nothing is granted
//   pending_mask : one bit per register with a write still held in a slot
//   conflict_cnt : saturating count of cycles with both slots pending
// Round-robin between the two slots; after any grant the other source has
// priority, so a waiting slot is served at most one cycle later.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int WORDSIZE = rf_wb_arbiter_pkg::WORDSIZE,
  parameter int REG_NUM  = rf_wb_arbiter_pkg::REG_NUM,
  parameter int AW       = rf_wb_arbiter_pkg::AW
) (
  input  logic                CLK,
  input  logic                reset,
  rf_wb_arbiter_if.slave      alu,
  rf_wb_arbiter_if.slave      mem,
  output logic                regwrite,
  output logic [AW-1:0]       write1,
  output logic [WORDSIZE-1:0] write_data,
  output logic [REG_NUM-1:0]  pending_mask,
  output logic [15:0]         conflict_cnt
);

  logic                alu_pend, mem_pend;
  logic [AW-1:0]       alu_rd, mem_rd;
  logic [WORDSIZE-1:0] alu_data, mem_data;
  logic                grant_alu, grant_mem;

  src_e        ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;

  wb_slot #(.WORDSIZE(WORDSIZE), .AW(AW)) u_alu_slot (
    .CLK     (CLK),
    .reset   (reset),
    .valid   (alu.valid),
    .ready   (alu.ready),
    .in_rd   (alu.rd),
    .in_data (alu.data),
    .grant   (grant_alu),
    .pend    (alu_pend),
    .rd      (alu_rd),
    .data    (alu_data)
  );

  wb_slot #(.WORDSIZE(WORDSIZE), .AW(AW)) u_mem_slot (
    .CLK     (CLK),
    .reset   (reset),
    .valid   (mem.valid),
    .ready   (mem.ready),
    .in_rd   (mem.rd),
    .in_data (mem.data),
    .grant   (grant_mem),
    .pend    (mem_pend),
    .rd      (mem_rd),
    .data    (mem_data)
  );

  // Grants are suppressed while reset is high so held entries are dropped
  // without reaching the register file.
  assign grant_alu = !reset && alu_pend && (!mem_pend || (ptr_q == SRC_ALU));
  assign grant_mem = !reset && mem_pend && (!alu_pend || (ptr_q == SRC_MEM));

  always_comb begin
    ptr_d = ptr_q;
    if (grant_alu) begin
      ptr_d = other_src(SRC_ALU);
    end else if (grant_mem) begin
      ptr_d = other_src(SRC_MEM);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (alu_pend && mem_pend && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr_q <= SRC_ALU;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    regwrite   = grant_alu || grant_mem;
    write1     = '0;
    write_data = '0;
    if (grant_alu) begin
      write1     = alu_rd;
      write_data = alu_data;
    end else if (grant_mem) begin
      write1     = mem_rd;
      write_data = mem_data;
    end
  end

  // x0 is never held, but bit 0 is tied off so the mask contract does not
  // depend on that.
  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_mask
      if (gi == 0) begin : g_zero
        assign pending_mask[gi] = 1'b0;
      end else begin : g_reg
        assign pending_mask[gi] = (alu_pend && (alu_rd == AW'(gi))) ||
                                  (mem_pend && (mem_rd == AW'(gi)));
      end
    end
  endgenerate

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        regwrite;
  logic [4:0]  write1;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [15:0] conflict_cnt;

  rf_wb_arbiter_if #(.WORDSIZE_P(32), .AW_P(5)) alu_if ();
  rf_wb_arbiter_if #(.WORDSIZE_P(32), .AW_P(5)) mem_if ();

  rf_wb_arbiter #(.WORDSIZE(32), .REG_NUM(32), .AW(5)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .alu          (alu_if),
    .mem          (mem_if),
    .regwrite     (regwrite),
    .write1       (write1),
    .write_data   (write_data),
    .pending_mask (pending_mask),
    .conflict_cnt (conflict_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf_model [32];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Write-port monitor: every write must match the head of the scoreboard,
  // including the cycle it appears in; idle cycles must drive zeros.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (regwrite === 1'b1) begin
        rf_model[write1] = write_data;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: rd=%0d data=%h cyc=%0d, required no write",
                   write1, write_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (write1 !== e.rd || write_data !== e.data || cyc !== e.cyc) begin
            failures++;
            $display("FAIL write: rd=%0d data=%h cyc=%0d, required rd=%0d data=%h cyc=%0d",
                     write1, write_data, cyc, e.rd, e.data, e.cyc);
          end else begin
            $display("write rd=%0d data=%h cyc=%0d ok", write1, write_data, cyc);
          end
        end
      end else begin
        checks++;
        if (regwrite !== 1'b0 || write1 !== 5'd0 || write_data !== 32'd0) begin
          failures++;
          $display("FAIL idle_port: regwrite=%b write1=%0d data=%h, required 0/0/0",
                   regwrite, write1, write_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input int at);
    exp_t e;
    e.rd = rd; e.data = data; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_if.valid = 1'b1; alu_if.rd = 5'd1; alu_if.data = 32'h1234;
    mem_if.valid = 1'b1; mem_if.rd = 5'd2; mem_if.data = 32'h5678;
    tick();
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (regwrite !== 1'b0 || alu_if.ready !== 1'b0 || mem_if.ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: regwrite=%b alu_ready=%b mem_ready=%b, required 0/0/0",
                 regwrite, alu_if.ready, mem_if.ready);
      end
      checks++;
      if (conflict_cnt !== 16'd0 || pending_mask !== 32'd0) begin
        failures++;
        $display("FAIL reset_state: cnt=%0d mask=%h, required 0/0", conflict_cnt, pending_mask);
      end
    end
    tick();
    reset = 1'b0;
    alu_if.valid = 1'b0;
    mem_if.valid = 1'b0;
    #1;
    checks++;
    if (alu_if.ready !== 1'b1 || mem_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: alu=%b mem=%b, required 1/1", alu_if.ready, mem_if.ready);
    end
    $display("reset test done");
  endtask

  task automatic test_contention();
    // Round 1: pointer is ALU after reset, so ALU goes first.
    tick();
    checks++;
    if (alu_if.ready !== 1'b1 || mem_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL cont_ready: alu=%b mem=%b, required 1/1", alu_if.ready, mem_if.ready);
    end
    alu_if.valid = 1'b1; alu_if.rd = 5'd7; alu_if.data = 32'hAAAA;
    mem_if.valid = 1'b1; mem_if.rd = 5'd8; mem_if.data = 32'hBBBB;
    push(5'd7, 32'hAAAA, cyc + 1);
    push(5'd8, 32'hBBBB, cyc + 2);
    tick();
    alu_if.valid = 1'b0; mem_if.valid = 1'b0;
    tick(); tick();
    checks++;
    if (conflict_cnt !== 16'd1) begin
      failures++;
      $display("FAIL conflict_cnt_1: got %0d, required 1", conflict_cnt);
    end
    // Round 2: a lone ALU write moves the pointer to MEM, then both offer.
    alu_if.valid = 1'b1; alu_if.rd = 5'd10; alu_if.data = 32'h10;
    push(5'd10, 32'h10, cyc + 1);
    tick();
    alu_if.valid = 1'b0;
    tick();
    alu_if.valid = 1'b1; alu_if.rd = 5'd11; alu_if.data = 32'h1111;
    mem_if.valid = 1'b1; mem_if.rd = 5'd12; mem_if.data = 32'h2222;
    push(5'd12, 32'h2222, cyc + 1);
    push(5'd11, 32'h1111, cyc + 2);
    tick();
    alu_if.valid = 1'b0; mem_if.valid = 1'b0;
    tick(); tick();
    checks++;
    if (conflict_cnt !== 16'd2) begin
      failures++;
      $display("FAIL conflict_cnt_2: got %0d, required 2", conflict_cnt);
    end
    $display("contention test done");
  endtask

  task automatic test_streaming();
    logic [4:0]  rds [3];
    logic [31:0] vals [3];
    rds[0] = 5'd3; rds[1] = 5'd4; rds[2] = 5'd5;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (alu_if.ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d]: got %b, required 1", i, alu_if.ready);
      end
      alu_if.valid = 1'b1; alu_if.rd = rds[i]; alu_if.data = vals[i];
      push(rds[i], vals[i], cyc + 1);
    end
    tick();
    alu_if.valid = 1'b0;
    tick(); tick();
    $display("streaming test done");
  endtask

  task automatic test_same_dest();
    // A lone MEM write leaves the pointer on ALU.
    mem_if.valid = 1'b1; mem_if.rd = 5'd6; mem_if.data = 32'h66;
    push(5'd6, 32'h66, cyc + 1);
    tick();
    mem_if.valid = 1'b0;
    tick();
    alu_if.valid = 1'b1; alu_if.rd = 5'd9; alu_if.data = 32'h1;
    mem_if.valid = 1'b1; mem_if.rd = 5'd9; mem_if.data = 32'h2;
    push(5'd9, 32'h1, cyc + 1);
    push(5'd9, 32'h2, cyc + 2);
    tick();
    alu_if.valid = 1'b0; mem_if.valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (pending_mask !== 32'h200) begin
      failures++;
      $display("FAIL mask_both_9: got %h, required 00000200", pending_mask);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (pending_mask !== 32'h200) begin
      failures++;
      $display("FAIL mask_mem_9: got %h, required 00000200", pending_mask);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (pending_mask !== 32'h0) begin
      failures++;
      $display("FAIL mask_clear_9: got %h, required 00000000", pending_mask);
    end
    checks++;
    if (rf_model[9] !== 32'h2) begin
      failures++;
      $display("FAIL same_dest_final: r9=%h, required 00000002", rf_model[9]);
    end
    checks++;
    if (conflict_cnt !== 16'd3) begin
      failures++;
      $display("FAIL conflict_cnt_3: got %0d, required 3", conflict_cnt);
    end
    $display("same destination test done");
  endtask

  task automatic test_x0_drop();
    tick();
    checks++;
    if (mem_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready: got %b, required 1", mem_if.ready);
    end
    mem_if.valid = 1'b1; mem_if.rd = 5'd0; mem_if.data = 32'hDEAD;
    tick();
    mem_if.valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (pending_mask !== 32'h0) begin
        failures++;
        $display("FAIL x0_mask[%0d]: got %h, required 00000000", i, pending_mask);
      end
      tick();
    end
    $display("x0 drop test done");
  endtask

  task automatic test_reset_mid();
    alu_if.valid = 1'b1; alu_if.rd = 5'd13; alu_if.data = 32'h13;
    mem_if.valid = 1'b1; mem_if.rd = 5'd14; mem_if.data = 32'h14;
    tick();
    alu_if.valid = 1'b0; mem_if.valid = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    checks++;
    if (regwrite !== 1'b0 || alu_if.ready !== 1'b0 || mem_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_port: regwrite=%b alu_ready=%b mem_ready=%b, required 0/0/0",
               regwrite, alu_if.ready, mem_if.ready);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (pending_mask !== 32'h0 || conflict_cnt !== 16'd0 || regwrite !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: mask=%h cnt=%0d regwrite=%b, required 0/0/0",
               pending_mask, conflict_cnt, regwrite);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (alu_if.ready !== 1'b1 || mem_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_release_ready: alu=%b mem=%b, required 1/1", alu_if.ready, mem_if.ready);
    end
    // Pointer is back on ALU after reset.
    alu_if.valid = 1'b1; alu_if.rd = 5'd15; alu_if.data = 32'h15;
    mem_if.valid = 1'b1; mem_if.rd = 5'd16; mem_if.data = 32'h16;
    push(5'd15, 32'h15, cyc + 1);
    push(5'd16, 32'h16, cyc + 2);
    tick();
    alu_if.valid = 1'b0; mem_if.valid = 1'b0;
    tick(); tick(); tick();
    $display("reset mid-operation test done");
  endtask

  initial begin
    alu_if.valid = 1'b0; alu_if.rd = '0; alu_if.data = '0;
    mem_if.valid = 1'b0; mem_if.rd = '0; mem_if.data = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset();
    test_contention();
    test_streaming();
    test_same_dest();
    test_x0_drop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
